// File: rtl/stage_sequencer.sv
// stage_sequencer: five-stage instruction sequencer with RAM handshake, timeout fault and retired-instruction counter
module stage_sequencer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Run,
  input  logic        Mem_Read,
  input  logic        Mem_Write,
  input  logic        Write_Back,
  input  logic        RAM1_MFC,
  output logic [2:0]  Stage,
  output logic        IR_Enable,
  output logic        PC_Enable,
  output logic        ROM1_Read,
  output logic        RA_Enable,
  output logic        RB_Enable,
  output logic        RZ_Enable,
  output logic        RM_Enable,
  output logic        RAM1_Read,
  output logic        RAM1_Read_H_Write_L,
  output logic        RY_Enable,
  output logic        RF_WRITE,
  output logic        Fault,
  output logic [15:0] Instr_Count
);
  localparam int CW = $clog2(MEM_TIMEOUT + 2);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXECUTE, MEMORY, MEM_WAIT, WRITEBACK, FAULT} state_t;
  state_t state, state_n;
  logic rd_q, wr_q, wb_q;
  logic [CW-1:0] wait_cnt;
  logic [15:0] instr_count;
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state       <= IDLE;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      wb_q        <= 1'b0;
      wait_cnt    <= '0;
      instr_count <= '0;
    end else begin
      state       <= state_n;
      rd_q        <= state == DECODE ? Mem_Read : rd_q;
      wr_q        <= state == DECODE ? Mem_Write : wr_q;
      wb_q        <= state == DECODE ? Write_Back : wb_q;
      wait_cnt    <= state == MEMORY ? '0 : (state == MEM_WAIT && !RAM1_MFC) ? wait_cnt + 1'b1 : wait_cnt;
      instr_count <= instr_count + 16'(state == WRITEBACK);
    end
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE:      state_n = Run ? FETCH : IDLE;
      FETCH:     state_n = DECODE;
      DECODE:    state_n = EXECUTE;
      EXECUTE:   state_n = MEMORY;
      MEMORY:    state_n = (rd_q && wr_q) ? FAULT : (rd_q || wr_q) ? MEM_WAIT : WRITEBACK;
      MEM_WAIT:  state_n = RAM1_MFC ? WRITEBACK : wait_cnt == CW'(MEM_TIMEOUT) ? FAULT : MEM_WAIT;
      WRITEBACK: state_n = Run ? FETCH : IDLE;
      FAULT:     state_n = FAULT;
    endcase
  end
  assign Stage = state == FETCH ? 3'd1 :
                 state == DECODE ? 3'd2 :
                 state == EXECUTE ? 3'd3 :
                 (state == MEMORY || state == MEM_WAIT) ? 3'd4 :
                 state == WRITEBACK ? 3'd5 : 3'd0;
  assign IR_Enable           = state == FETCH;
  assign PC_Enable           = state == FETCH;
  assign ROM1_Read           = state == FETCH;
  assign RA_Enable           = state == DECODE;
  assign RB_Enable           = state == DECODE;
  assign RZ_Enable           = state == EXECUTE;
  assign RM_Enable           = state == EXECUTE;
  assign RAM1_Read           = state == MEM_WAIT && rd_q;
  assign RAM1_Read_H_Write_L = !(state == MEM_WAIT && wr_q);
  assign RY_Enable           = (state == MEMORY && !rd_q && !wr_q) || (state == MEM_WAIT && rd_q && RAM1_MFC);
  assign RF_WRITE            = state == WRITEBACK && wb_q;
  assign Fault               = state == FAULT;
  assign Instr_Count         = instr_count;
endmodule
